// File: rtl/expr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | expr_pkg: shared constants for the expression-stream token emitter    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package expr_pkg;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_MUL  = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;

   localparam logic TK_DIG = 1'b0;
   localparam logic TK_OP  = 1'b1;

   localparam int          ST_W       = 2;
   localparam logic [ST_W-1:0] ST_EXP_DIG = 2'd0;
   localparam logic [ST_W-1:0] ST_EXP_OP  = 2'd1;
   localparam logic [ST_W-1:0] ST_ERR     = 2'd2;
   localparam logic [ST_W-1:0] ST_TERM    = 2'd3;

   function automatic logic [7:0] op_char(input logic code);
      return code ? CH_MUL : CH_PLUS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/expr_emit_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | expr_emit_fifo: byte FIFO whose head is held in a register (dout)     |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module expr_emit_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] dout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    dout_q, dout_d;
   logic          do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = dout_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Head register tracks the next-cycle head so a pushed byte is visible one edge later.
      dout_d = (count_d != '0) ? mem_d[rd_ptr_d] : dout_q;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/expr_emitter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | expr_emitter: grammar-checking token-to-ASCII serializer with FIFO    |
// | Optional '=' terminator after each expression: EXPR_EMITTER_TERM_EN   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module expr_emitter
   import expr_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       tok_valid,
   output logic       tok_ready,
   input  logic       tok_kind,
   input  logic [3:0] tok_val,
   input  logic       tok_last,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       expr_done,
   output logic       err
);

`ifdef EXPR_EMITTER_TERM_EN
   localparam logic [ST_W-1:0] ST_AFTER_LAST = ST_TERM;
`else
   localparam logic [ST_W-1:0] ST_AFTER_LAST = ST_EXP_DIG;
`endif

   logic [ST_W-1:0] state_q, state_d;
   logic            err_q, err_d;
   logic            done_q, done_d;

   logic       fifo_full, fifo_empty;
   logic       push, pop;
   logic [7:0] push_data;
   logic       accept, digit_ok, op_ok;

   // Gated by clr_n so the source sees no ready while reset is held.
   assign tok_ready = clr_n && !fifo_full && (state_q != ST_TERM);
   assign accept    = tok_valid && tok_ready;
   assign digit_ok  = (tok_kind == TK_DIG) && (tok_val <= 4'd9);
   assign op_ok     = (tok_kind == TK_OP) && (tok_val <= 4'd1);
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign expr_done = done_q;
   assign err       = err_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_EXP_DIG;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EXP_DIG: begin
            if (accept) begin
               if (digit_ok) state_d = tok_last ? ST_AFTER_LAST : ST_EXP_OP;
               else          state_d = tok_last ? ST_EXP_DIG : ST_ERR;
            end
         end
         ST_EXP_OP: begin
            if (accept) begin
               if (op_ok) state_d = ST_EXP_DIG;
               else       state_d = tok_last ? ST_EXP_DIG : ST_ERR;
            end
         end
         ST_ERR: begin
            if (accept && tok_last) state_d = ST_EXP_DIG;
         end
`ifdef EXPR_EMITTER_TERM_EN
         ST_TERM: begin
            if (!fifo_full) state_d = ST_EXP_DIG;
         end
`endif
         default: state_d = ST_EXP_DIG;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      push_data = 8'h00;
      err_d     = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_EXP_DIG: begin
            if (accept) begin
               if (digit_ok) begin
                  push      = 1'b1;
                  push_data = CH_0 + {4'd0, tok_val};
`ifndef EXPR_EMITTER_TERM_EN
                  done_d    = tok_last;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_EXP_OP: begin
            if (accept) begin
               if (op_ok) begin
                  // A trailing operator is still emitted but flags the expression as broken.
                  push      = 1'b1;
                  push_data = op_char(tok_val[0]);
                  err_d     = tok_last;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
`ifdef EXPR_EMITTER_TERM_EN
         ST_TERM: begin
            if (!fifo_full) begin
               push      = 1'b1;
               push_data = CH_EQ;
               done_d    = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   expr_emit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .dout      (out_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_expr_emitter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_expr_emitter: random + directed bench with an in-bench token model |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_expr_emitter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       clr_n, tok_valid, tok_kind, tok_last, out_ready;
   logic [3:0] tok_val;
   logic       tok_ready, out_valid, expr_done, err;
   logic [7:0] out_data;

   always #5 clk = ~clk;

   expr_emitter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .tok_kind  (tok_kind),
      .tok_val   (tok_val),
      .tok_last  (tok_last),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .expr_done (expr_done),
      .err       (err)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] seen[$];
   int         err_cnt  = 0;
   int         done_cnt = 0;
   bit         rand_ready = 1'b0;
   logic [7:0] exp_q[$];
   int         sb, eb, db;

   // Reference: bytes waiting at the output, and where we are in the grammar.
   logic [7:0] q[$];
   int         m_mode;   // 0 want digit, 1 want op, 2 skipping to last, 3 owe '='
   bit         m_err, m_done;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return clr_n && (q.size() < DEPTH) && (m_mode != 3);
   endfunction

   task automatic m_reset();
      q.delete();
      m_mode = 0;
      m_err  = 1'b0;
      m_done = 1'b0;
   endtask

   task automatic m_step();
      bit         acc, pop, room, push, e, d;
      logic [7:0] pb;
      acc  = tok_valid && m_ready();
      pop  = (q.size() > 0) && out_ready;
      room = q.size() < DEPTH;
      push = 1'b0; e = 1'b0; d = 1'b0; pb = 8'h00;
      if (out_valid && out_ready) seen.push_back(out_data);
      if (m_mode == 3) begin
         if (room) begin push = 1'b1; pb = 8'h3D; d = 1'b1; m_mode = 0; end
      end else if (acc) begin
         if (m_mode == 0) begin
            if (tok_kind == 1'b0 && tok_val <= 9) begin
               push = 1'b1; pb = 8'h30 + {4'd0, tok_val};
`ifdef EXPR_EMITTER_TERM_EN
               m_mode = tok_last ? 3 : 1;
`else
               d = tok_last; m_mode = tok_last ? 0 : 1;
`endif
            end else begin
               e = 1'b1; m_mode = tok_last ? 0 : 2;
            end
         end else if (m_mode == 1) begin
            if (tok_kind == 1'b1 && tok_val <= 1) begin
               push = 1'b1; pb = (tok_val == 0) ? 8'h2B : 8'h2A;
               e = tok_last; m_mode = 0;
            end else begin
               e = 1'b1; m_mode = tok_last ? 0 : 2;
            end
         end else if (tok_last) begin
            m_mode = 0;
         end
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(pb);
      m_err  = e;
      m_done = d;
   endtask

   // One clock: model consumes current inputs, then outputs are compared after the edge.
   task automatic tick();
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      m_step();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("tok_ready", tok_ready, m_ready());
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("out_data", out_data, q[0]);
      chk("err", err, m_err);
      chk("expr_done", expr_done, m_done);
      if (err) err_cnt++;
      if (expr_done) done_cnt++;
   endtask

   task automatic idle(int n);
      tok_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(bit k, logic [3:0] v, bit l);
      bit acc;
      tok_valid = 1'b1; tok_kind = k; tok_val = v; tok_last = l;
      for (int n = 0; n < 64; n++) begin
         acc = m_ready();
         tick();
         if (acc) begin
            tok_valid = 1'b0;
            return;
         end
      end
      tok_valid = 1'b0;
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted at %0t", $time);
   endtask

   task automatic mark();
      sb = seen.size(); eb = err_cnt; db = done_cnt;
   endtask

   task automatic check_run(string name, int e_err, int e_done);
      int n;
      n = seen.size() - sb;
      chk({name, "_nbytes"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         chk({name, "_byte"}, seen[sb + i], exp_q[i]);
      chk({name, "_err_pulses"}, err_cnt - eb, e_err);
      chk({name, "_done_pulses"}, done_cnt - db, e_done);
      chk({name, "_model_drained"}, q.size(), 0);
   endtask

   task automatic chk_reset_vals(string name);
      chk({name, "_out_valid"}, out_valid, 0);
      chk({name, "_tok_ready"}, tok_ready, 0);
      chk({name, "_out_data"}, out_data, 0);
      chk({name, "_err"}, err, 0);
      chk({name, "_done"}, expr_done, 0);
   endtask

   initial begin
      clr_n = 1'b0; tok_valid = 1'b0; tok_kind = 1'b0; tok_val = 4'd0;
      tok_last = 1'b0; out_ready = 1'b0;
      m_reset();
      #3;
      chk_reset_vals("reset");
      @(negedge clk); #1;
      clr_n = 1'b1;

      // Legal stream 0 * 9 + 3(last)
      out_ready = 1'b1;
      mark();
      send(0, 0, 0); send(1, 1, 0); send(0, 9, 0); send(1, 0, 0); send(0, 3, 1);
      idle(8);
      exp_q = '{8'h30, 8'h2A, 8'h39, 8'h2B, 8'h33};
`ifdef EXPR_EMITTER_TERM_EN
      exp_q.push_back(8'h3D);
`endif
      check_run("legal", 0, 1);

      // Two digits in a row, then skip until last
      mark();
      send(0, 4, 0); send(0, 5, 0); send(1, 0, 0); send(0, 1, 1); send(0, 7, 1);
      idle(8);
      exp_q = '{8'h34, 8'h37};
`ifdef EXPR_EMITTER_TERM_EN
      exp_q.push_back(8'h3D);
`endif
      check_run("grammar", 1, 1);

      // Out-of-range digit and op code
      mark();
      send(0, 12, 1); send(0, 2, 0); send(1, 3, 1); send(0, 6, 1);
      idle(8);
      exp_q = '{8'h32, 8'h36};
`ifdef EXPR_EMITTER_TERM_EN
      exp_q.push_back(8'h3D);
`endif
      check_run("illegal", 2, 1);

      // Backpressure fills the FIFO
      out_ready = 1'b0;
      mark();
      send(0, 1, 0); send(1, 0, 0); send(0, 2, 0); send(1, 1, 0);
      chk("bp_ready_low", tok_ready, 0);
      out_ready = 1'b1;
      idle(2);
      send(0, 5, 1);
      idle(8);
      exp_q = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h35};
`ifdef EXPR_EMITTER_TERM_EN
      exp_q.push_back(8'h3D);
`endif
      check_run("backpressure", 0, 1);

      // Trailing operator
      mark();
      send(0, 1, 0); send(1, 0, 1);
      idle(6);
      exp_q = '{8'h31, 8'h2B};
      check_run("trailing_op", 1, 0);

      // Reset in the middle of a burst
      out_ready = 1'b0;
      send(0, 1, 0); send(1, 1, 0); send(0, 2, 0);
      clr_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      m_reset();
      @(posedge clk); @(negedge clk); #1;
      clr_n = 1'b1;
      out_ready = 1'b1;
      mark();
      send(0, 7, 1);
      idle(6);
      exp_q = '{8'h37};
`ifdef EXPR_EMITTER_TERM_EN
      exp_q.push_back(8'h3D);
`endif
      check_run("after_reset", 0, 1);

      // Randomized tokens with random sink stalls
      rand_ready = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         bit         k;
         logic [3:0] v;
         int         r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 7) == 0) idle(1);
         k = (r < 85) ? (m_mode == 1) : (m_mode != 1);
         if ((r % 10) < 8) v = k ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 9));
         else              v = 4'($urandom_range(0, 15));
         send(k, v, $urandom_range(0, 4) == 0);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      idle(12);
      chk("final_drained", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
